// File: rtl/branch_predict_unit.sv
// Branch resolver plus 2-bit bimodal predictor indexed by pc[IDX_W+1:2]; optional BRANCH_STATS_EN adds stats counters.
// Latency: prediction and resolution results are both registered, one cycle after the sampling edge.
// Backpressure: none; accepts one prediction and one resolution every cycle.
module branch_predict_unit #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_taken_valid,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [PC_W-1:0] res_pc,
  input  logic [2:0]      res_branch,
  input  logic [2:0]      res_flags,
  input  logic            res_predicted,
  output logic            branchf,
  output logic            mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_mispredicts
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       ctr [DEPTH];
  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] ridx;
  logic             taken;
  logic             upd;
  logic             mis_now;

  assign pidx    = pred_pc[IDX_W+1:2];
  assign ridx    = res_pc[IDX_W+1:2];
  assign upd     = res_valid && (res_branch != 3'b000);
  assign mis_now = res_valid && (taken != res_predicted);

  // Byte-offset and tag bits are deliberately ignored; aliasing is accepted.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                            res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

  // Flags are {Z, N, C}.
  always_comb begin
    taken = 1'b0;
    case (res_branch)
      3'b000: taken = 1'b0;
      3'b001: taken = 1'b1;
      3'b010: taken = res_flags[2];
      3'b011: taken = ~res_flags[2];
      3'b100: taken = res_flags[1];
      3'b101: taken = ~res_flags[1];
      3'b110: taken = res_flags[0];
      3'b111: taken = ~res_flags[0];
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= 2'b01;
      pred_taken_valid <= 1'b0;
      pred_taken       <= 1'b0;
      branchf          <= 1'b0;
      mispredict       <= 1'b0;
    end else begin
      // Prediction reads the table before this edge's update lands.
      pred_taken_valid <= pred_valid;
      pred_taken       <= pred_valid & ctr[pidx][1];
      branchf          <= res_valid & taken;
      mispredict       <= mis_now;
      if (upd) begin
        if (taken && ctr[ridx] != 2'b11)
          ctr[ridx] <= ctr[ridx] + 2'd1;
        else if (!taken && ctr[ridx] != 2'b00)
          ctr[ridx] <= ctr[ridx] - 2'd1;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= 16'h0000;
      stat_mispredicts <= 16'h0000;
    end else begin
      if (upd && stat_branches != 16'hFFFF)
        stat_branches <= stat_branches + 16'd1;
      if (mis_now && stat_mispredicts != 16'hFFFF)
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default PC_W=32, IDX_W=4).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_taken_valid;
  logic        pred_taken;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic [2:0]  res_branch = '0;
  logic [2:0]  res_flags = '0;
  logic        res_predicted = 1'b0;
  logic        branchf;
  logic        mispredict;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.PC_W(32), .IDX_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .pred_valid(pred_valid),
    .pred_pc(pred_pc),
    .pred_taken_valid(pred_taken_valid),
    .pred_taken(pred_taken),
    .res_valid(res_valid),
    .res_pc(res_pc),
    .res_branch(res_branch),
    .res_flags(res_flags),
    .res_predicted(res_predicted),
    .branchf(branchf),
    .mispredict(mispredict)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid    = 1'b0;
    pred_pc       = '0;
    res_valid     = 1'b0;
    res_pc        = '0;
    res_branch    = '0;
    res_flags     = '0;
    res_predicted = 1'b0;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic [2:0] mode,
                         input logic [2:0] flags, input logic predicted);
    res_valid     = 1'b1;
    res_pc        = pc;
    res_branch    = mode;
    res_flags     = flags;
    res_predicted = predicted;
  endtask

  task automatic set_pred(input logic [31:0] pc);
    pred_valid = 1'b1;
    pred_pc    = pc;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({pred_taken_valid, pred_taken, branchf, mispredict} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000",
               {pred_taken_valid, pred_taken, branchf, mispredict});
    end
    reset = 1'b0;
    set_pred(32'h40);
    tick();
    total++;
    if (pred_taken_valid !== 1'b1 || pred_taken !== 1'b0) begin
      bad++;
      $display("FAIL reset_predict got=%b%b want=10", pred_taken_valid, pred_taken);
    end
    total++;
    if (branchf !== 1'b0 || mispredict !== 1'b0) begin
      bad++;
      $display("FAIL reset_resolve got=%b%b want=00", branchf, mispredict);
    end
    idle();
    tick();
    total++;
    if (pred_taken_valid !== 1'b0 || pred_taken !== 1'b0) begin
      bad++;
      $display("FAIL pred_valid_drop got=%b%b want=00", pred_taken_valid, pred_taken);
    end
  endtask

  // res_predicted is held at 0, so every taken resolve counts as a mispredict.
  task automatic test_training();
    for (int i = 0; i < 3; i++) begin
      set_res(32'h40, 3'b010, 3'b100, 1'b0);
      tick();
      total++;
      if (branchf !== 1'b1 || mispredict !== 1'b1) begin
        bad++;
        $display("FAIL train_%0d got=%b%b want=11", i, branchf, mispredict);
      end
    end
    idle();
    set_pred(32'h40);
    tick();
    total++;
    if (pred_taken !== 1'b1 || mispredict !== 1'b0 || branchf !== 1'b0) begin
      bad++;
      $display("FAIL train_predict got pt=%b mp=%b bf=%b want 1 0 0",
               pred_taken, mispredict, branchf);
    end
    idle();
  endtask

  task automatic test_mode_decode();
    logic [7:0] exp_f0;
    logic [7:0] exp_f7;
    exp_f0 = 8'b1010_1010;
    exp_f7 = 8'b0101_0110;
    for (int m = 0; m < 8; m++) begin
      set_res(32'h44, 3'(m), 3'b000, 1'b0);
      tick();
      total++;
      if (branchf !== exp_f0[m] || mispredict !== exp_f0[m]) begin
        bad++;
        $display("FAIL mode%0d_flags000 got=%b%b want=%b%b", m, branchf, mispredict,
                 exp_f0[m], exp_f0[m]);
      end
      set_res(32'h44, 3'(m), 3'b111, 1'b0);
      tick();
      total++;
      if (branchf !== exp_f7[m] || mispredict !== exp_f7[m]) begin
        bad++;
        $display("FAIL mode%0d_flags111 got=%b%b want=%b%b", m, branchf, mispredict,
                 exp_f7[m], exp_f7[m]);
      end
    end
    // Mode 000 must mispredict when predicted taken but leave the counter at 01.
    set_res(32'h48, 3'b000, 3'b111, 1'b1);
    tick();
    total++;
    if (branchf !== 1'b0 || mispredict !== 1'b1) begin
      bad++;
      $display("FAIL mode0_pred1 got=%b%b want=01", branchf, mispredict);
    end
    idle();
    tick();
    total++;
    if (mispredict !== 1'b0) begin
      bad++;
      $display("FAIL mispredict_one_cycle got=%b want=0", mispredict);
    end
    // One taken step from an untouched 01 reaches 10 -> predicts taken.
    set_res(32'h48, 3'b001, 3'b000, 1'b1);
    tick();
    idle();
    set_pred(32'h48);
    tick();
    total++;
    if (pred_taken !== 1'b1) begin
      bad++;
      $display("FAIL mode0_no_update got=%b want=1", pred_taken);
    end
    idle();
  endtask

  task automatic test_hazard();
    set_res(32'h4C, 3'b001, 3'b000, 1'b0);
    set_pred(32'h4C);
    tick();
    total++;
    if (pred_taken !== 1'b0 || pred_taken_valid !== 1'b1) begin
      bad++;
      $display("FAIL hazard_same_cycle got=%b%b want=10", pred_taken_valid, pred_taken);
    end
    idle();
    set_pred(32'h4C);
    tick();
    total++;
    if (pred_taken !== 1'b1) begin
      bad++;
      $display("FAIL hazard_next_cycle got=%b want=1", pred_taken);
    end
    idle();
  endtask

  // Index 4: mode 011 taken,taken,not-taken, then idle: counter 01->10->11->10.
  task automatic test_back_to_back();
    logic [2:0] flg [4];
    logic       rv  [4];
    logic       ebf [4];
    logic       ept [4];
    flg = '{3'b000, 3'b000, 3'b100, 3'b000};
    rv  = '{1'b1, 1'b1, 1'b1, 1'b0};
    ebf = '{1'b1, 1'b1, 1'b0, 1'b0};
    ept = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      idle();
      if (rv[i]) set_res(32'h50, 3'b011, flg[i], 1'b0);
      set_pred(32'h50);
      tick();
      total++;
      if (branchf !== ebf[i] || mispredict !== ebf[i] || pred_taken !== ept[i]) begin
        bad++;
        $display("FAIL b2b_%0d got bf=%b mp=%b pt=%b want %b %b %b", i,
                 branchf, mispredict, pred_taken, ebf[i], ebf[i], ept[i]);
      end
    end
    idle();
  endtask

  task automatic test_alias_reset();
    set_pred(32'h40 + (32'd4 << 4));
    tick();
    total++;
    if (pred_taken !== 1'b1) begin
      bad++;
      $display("FAIL alias_predict got=%b want=1", pred_taken);
    end
    set_res(32'h48, 3'b001, 3'b000, 1'b0);
    set_pred(32'h40);
    reset = 1'b1;
    tick();
    total++;
    if ({pred_taken_valid, pred_taken, branchf, mispredict} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_midstream got=%b want=0000",
               {pred_taken_valid, pred_taken, branchf, mispredict});
    end
    reset = 1'b0;
    idle();
    tick();
    total++;
    if (mispredict !== 1'b0 || branchf !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_pulse got=%b%b want=00", branchf, mispredict);
    end
    set_pred(32'h40);
    tick();
    total++;
    if (pred_taken !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctr_0x40 got=%b want=0", pred_taken);
    end
    // 01 + one taken -> 10; a counter left at 00 or 11 would not give this result.
    idle();
    set_res(32'h50, 3'b001, 3'b000, 1'b1);
    tick();
    idle();
    set_pred(32'h50);
    tick();
    total++;
    if (pred_taken !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctr_0x50 got=%b want=1", pred_taken);
    end
    idle();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    total++;
    if (stat_branches !== 16'd0 || stat_mispredicts !== 16'd0) begin
      bad++;
      $display("FAIL stats_reset got=%0d/%0d want=0/0", stat_branches, stat_mispredicts);
    end
    set_res(32'h54, 3'b001, 3'b000, 1'b1); tick();
    set_res(32'h54, 3'b001, 3'b000, 1'b0); tick();
    set_res(32'h54, 3'b010, 3'b000, 1'b0); tick();
    set_res(32'h54, 3'b010, 3'b100, 1'b0); tick();
    set_res(32'h54, 3'b111, 3'b000, 1'b1); tick();
    set_res(32'h54, 3'b000, 3'b000, 1'b0); tick();
    idle();
    tick();
    total++;
    if (stat_branches !== 16'd5 || stat_mispredicts !== 16'd2) begin
      bad++;
      $display("FAIL stats_count got=%0d/%0d want=5/2", stat_branches, stat_mispredicts);
    end
    set_res(32'h54, 3'b001, 3'b000, 1'b0);
    for (int i = 0; i < 65540; i++) tick();
    idle();
    tick();
    total++;
    if (stat_branches !== 16'hFFFF || stat_mispredicts !== 16'hFFFF) begin
      bad++;
      $display("FAIL stats_saturate got=%h/%h want=ffff/ffff",
               stat_branches, stat_mispredicts);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_training();
    test_mode_decode();
    test_hazard();
    test_back_to_back();
    test_alias_reset();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
